pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID/EX pipeline registers around the decode stage. Emits keep/nop/flush
//  and the per-operand forwarding selects that decode consumes. Handles load-use stalls,
//  EX-stage redirects, ecall/mret drain and data-memory wait through a 5-state FSM.
//  Sits beside decode; it holds no datapath values, only control.
// PARAMETERS
//  TRAP_DRAIN  2  cycles the front end is held after a trap/mret reaches EX (>=1)
//  RA_W        5  register-address width
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset; one clock, synchronous, active-low
//  id_rs1/id_rs2 in   RA_W  source regs of the instruction in ID
//  id_use1/id_use2 in 1     ID instruction actually reads rs1/rs2
//  ex_wreg       in   RA_W  destination reg in EX
//  ex_regwrite   in   1     EX instruction writes a reg
//  ex_load       in   1     EX instruction is a load (MemRW==2'b10)
//  mem_wreg      in   RA_W  destination reg in MEM
//  mem_regwrite  in   1     MEM instruction writes a reg
//  ex_redirect   in   1     EX resolved taken branch/jump or mispredict
//  ex_trap       in   1     ecall or mret is in EX
//  dmem_busy     in   1     data memory not ready this cycle
//  if_keep       out  1     hold PC and IF/ID
//  id_keep       out  1     hold ID/EX (decode keep)
//  id_nop        out  1     insert bubble into ID/EX (decode nop)
//  if_flush      out  1     squash IF/ID contents
//  fwd_ex        out  2     [1]=rs1,[0]=rs2 take EX result
//  fwd_mem       out  2     [1]=rs1,[0]=rs2 take MEM result
//  fwd_load      out  2     [1]=rs1,[0]=rs2 take load data after a load-use stall
//  trap_go       out  1     1-cycle pulse: drain done, PC may load mtvec/mepc
//  state_o       out  3     current FSM state (debug)
// BEHAVIOUR
//  - While rst=0: state<=RUN, drain counter<=0, fwd_load reg<=0. Every output is 0 (state_o=RUN).
//  - States: RUN, LDSTALL, FLUSH, DRAIN, MWAIT. Outputs combinational from state+inputs.
//  - Priority per cycle: dmem_busy > ex_trap > ex_redirect > load-use > forwarding.
//  - Hazard match needs reg!=0 and the matching id_use; x0 never matches.
//  - MWAIT: entered from any state when dmem_busy=1. if_keep=id_keep=1, id_nop=0.
//    The prior state and counter are frozen. Resume the frozen state the cycle after busy drops.
//  - Load-use (RUN, ex_load & ex_regwrite & ex_wreg matches rs1/rs2): if_keep=1, id_nop=1.
//    Latch the match bits into the fwd_load reg. Next state LDSTALL.
//  - LDSTALL: 1 cycle. fwd_load=latched bits, no stall. Clear the reg, go to RUN.
//    A new load-use in LDSTALL re-enters LDSTALL.
//  - ex_redirect (RUN/LDSTALL): if_flush=1, id_nop=1 this cycle. Next state FLUSH.
//    A simultaneous load-use is ignored, because the instruction in ID is squashed.
//  - FLUSH: 1 cycle, outputs idle. Go to RUN. A redirect during FLUSH restarts FLUSH.
//  - ex_trap: id_nop=1, if_keep=1. Load counter=TRAP_DRAIN-1 and go to DRAIN.
//  - DRAIN: if_keep=1, id_nop=1, counter decrements each cycle.
//    At counter==0: trap_go=1 and if_flush=1, next state RUN.
//    ex_redirect and load-use are ignored in DRAIN.
//  - fwd_ex[i] = use_i & ex_regwrite & !ex_load & ex_wreg==rs_i.
//  - fwd_mem[i] = use_i & mem_regwrite & mem_wreg==rs_i & !fwd_ex[i]. EX beats MEM.
//  - Forwarding bits are forced 0 when id_nop, if_flush or id_keep is 1.
//  - id_keep and id_nop are never both 1.
// STRUCTURE
//  - define.v gains `HZ_RUN..`HZ_MWAIT (3-bit state codes) and `MEMRW_LOAD.
//  - Sub-module hazard_reg_match: combinational rs1/rs2 vs wreg compare with x0 masking.
//    Instantiated for EX and for MEM.
//  - FSM, drain counter ($clog2(TRAP_DRAIN)+1 bits) and fwd_load reg live in the top module.
// TESTING
//  - lw x5 in EX, ID add x6,x5,x1 -> cycle0: if_keep=1, id_nop=1.
//    cycle1: state=LDSTALL, fwd_load=2'b10. cycle2: RUN.
//  - ex_wreg=x3 (alu), mem_wreg=x3, rs1=rs2=x3 -> fwd_ex=2'b11, fwd_mem=2'b00.
//    With ex_wreg=x0 instead -> fwd_ex=00, fwd_mem=11.
//  - ex_redirect and load-use in the same cycle -> if_flush=1, id_nop=1, fwd_load stays 00.
//    Next state FLUSH, then RUN.
//  - ex_trap, TRAP_DRAIN=2 -> id_nop=1 for cycles 0..2, trap_go=1 and if_flush=1 in cycle 2.
//    ex_redirect in cycle 1 has no effect.
//  - Load-use, then dmem_busy=1 for 3 cycles in LDSTALL -> if_keep=id_keep=1 for 3 cycles.
//    Then LDSTALL resumes with fwd_load intact.
//  - rst=0 asserted in DRAIN with counter=1 -> next edge: state=RUN, all outputs 0.
//    After release, no trap_go is emitted.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state codes and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   // 3-bit FSM state codes; RUN is zero so a reset controller reports 0.
   typedef enum logic [2:0] {
      HZ_RUN     = 3'd0,
      HZ_LDSTALL = 3'd1,
      HZ_FLUSH   = 3'd2,
      HZ_DRAIN   = 3'd3,
      HZ_MWAIT   = 3'd4
   } hz_state_t;

   // MemRW encoding that marks a load in the EX stage.
   localparam logic [1:0] MEMRW_LOAD = 2'b10;

   // Number of source operands checked per instruction (rs1, rs2).
   localparam int NUM_SRC = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// Combinational rs1/rs2 versus destination-register compare.
// Bit 1 is rs1, bit 0 is rs2. x0 never matches, and an operand that the
// instruction does not actually read never matches.
module hazard_reg_match
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0]    rs1,
   input  logic [RA_W-1:0]    rs2,
   input  logic               use1,
   input  logic               use2,
   input  logic [RA_W-1:0]    wreg,
   output logic [NUM_SRC-1:0] hit
);

   logic [NUM_SRC-1:0][RA_W-1:0] rs_vec;
   logic [NUM_SRC-1:0]           use_vec;

   assign rs_vec  = {rs1, rs2};
   assign use_vec = {use1, use2};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign hit[gi] = use_vec[gi] && (rs_vec[gi] != '0) && (rs_vec[gi] == wreg);
      end
   endgenerate

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives IF/ID/EX keep, nop and flush controls
// and per-operand forwarding selects for the decode stage. Handles load-use
// stalls, EX redirects, trap drain and data-memory wait with a 5-state FSM.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int TRAP_DRAIN = 2,
   parameter int RA_W       = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_use1,
   input  logic            id_use2,
   input  logic [RA_W-1:0] ex_wreg,
   input  logic            ex_regwrite,
   input  logic            ex_load,
   input  logic [RA_W-1:0] mem_wreg,
   input  logic            mem_regwrite,
   input  logic            ex_redirect,
   input  logic            ex_trap,
   input  logic            dmem_busy,
   output logic            if_keep,
   output logic            id_keep,
   output logic            id_nop,
   output logic            if_flush,
   output logic [1:0]      fwd_ex,
   output logic [1:0]      fwd_mem,
   output logic [1:0]      fwd_load,
   output logic            trap_go,
   output logic [2:0]      state_o
);

   localparam int            CW         = $clog2(TRAP_DRAIN) + 1;
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(TRAP_DRAIN - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   hz_state_t     state_reg, state_next;
   hz_state_t     prior_reg, prior_next;   // state frozen while memory is busy
   hz_state_t     cur_state;               // state whose behaviour applies this cycle
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]    fwd_load_reg, fwd_load_next;

   logic [1:0]    ex_hit, mem_hit;
   logic [1:0]    ex_fwd_raw, mem_fwd_raw;
   logic [1:0]    lu_bits;
   logic          load_use;
   logic          fwd_en;

   hazard_reg_match #(.RA_W(RA_W)) u_ex_match (
      .rs1  (id_rs1),
      .rs2  (id_rs2),
      .use1 (id_use1),
      .use2 (id_use2),
      .wreg (ex_wreg),
      .hit  (ex_hit)
   );

   hazard_reg_match #(.RA_W(RA_W)) u_mem_match (
      .rs1  (id_rs1),
      .rs2  (id_rs2),
      .use1 (id_use1),
      .use2 (id_use2),
      .wreg (mem_wreg),
      .hit  (mem_hit)
   );

   // EX result beats MEM result; a load in EX cannot forward yet (load-use).
   assign ex_fwd_raw  = ex_hit  & {2{ex_regwrite & ~ex_load}};
   assign mem_fwd_raw = mem_hit & {2{mem_regwrite}} & ~ex_fwd_raw;
   assign lu_bits     = ex_hit  & {2{ex_load & ex_regwrite}};
   assign load_use    = |lu_bits;

   // State register, drain counter and latched load-forward bits.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= HZ_RUN;
         prior_reg    <= HZ_RUN;
         cnt_reg      <= '0;
         fwd_load_reg <= '0;
      end else begin
         state_reg    <= state_next;
         prior_reg    <= prior_next;
         cnt_reg      <= cnt_next;
         fwd_load_reg <= fwd_load_next;
      end
   end

   // Next-state and control outputs, highest-priority condition first.
   always_comb begin
      state_next    = state_reg;
      prior_next    = prior_reg;
      cnt_next      = cnt_reg;
      fwd_load_next = fwd_load_reg;
      if_keep       = 1'b0;
      id_keep       = 1'b0;
      id_nop        = 1'b0;
      if_flush      = 1'b0;
      trap_go       = 1'b0;
      fwd_en        = 1'b0;
      fwd_load      = 2'b00;
      fwd_ex        = 2'b00;
      fwd_mem       = 2'b00;
      state_o       = state_reg;

      // Once busy drops, MWAIT behaves exactly like the state it froze.
      cur_state = (state_reg == HZ_MWAIT) ? prior_reg : state_reg;

      if (dmem_busy) begin
         if_keep    = 1'b1;
         id_keep    = 1'b1;
         state_next = HZ_MWAIT;
         if (state_reg != HZ_MWAIT) begin
            prior_next = state_reg;
         end
      end else begin
         case (cur_state)
            HZ_DRAIN: begin
               // Front end held until the drain count expires; redirects
               // and load-use are irrelevant while draining.
               if_keep = 1'b1;
               id_nop  = 1'b1;
               if (cnt_reg == '0) begin
                  trap_go    = 1'b1;
                  if_flush   = 1'b1;
                  state_next = HZ_RUN;
               end else begin
                  cnt_next   = cnt_reg - CNT_ONE;
                  state_next = HZ_DRAIN;
               end
            end
            default: begin
               if (ex_trap) begin
                  id_nop        = 1'b1;
                  if_keep       = 1'b1;
                  cnt_next      = DRAIN_LOAD;
                  fwd_load_next = 2'b00;
                  state_next    = HZ_DRAIN;
               end else if (ex_redirect) begin
                  // ID is squashed, so any load-use on it is moot.
                  if_flush      = 1'b1;
                  id_nop        = 1'b1;
                  fwd_load_next = 2'b00;
                  state_next    = HZ_FLUSH;
               end else if (cur_state == HZ_FLUSH) begin
                  state_next = HZ_RUN;
               end else if (load_use) begin
                  if_keep       = 1'b1;
                  id_nop        = 1'b1;
                  fwd_load_next = lu_bits;
                  state_next    = HZ_LDSTALL;
               end else begin
                  fwd_en = 1'b1;
                  if (cur_state == HZ_LDSTALL) begin
                     fwd_load = fwd_load_reg;
                  end
                  fwd_load_next = 2'b00;
                  state_next    = HZ_RUN;
               end
            end
         endcase
      end

      // Forwarding only matters for an instruction that actually advances.
      if (fwd_en && !(id_nop || if_flush || id_keep)) begin
         fwd_ex  = ex_fwd_raw;
         fwd_mem = mem_fwd_raw;
      end else begin
         fwd_load = 2'b00;
      end

      // Reset forces every output idle regardless of inputs.
      if (!rst) begin
         if_keep  = 1'b0;
         id_keep  = 1'b0;
         id_nop   = 1'b0;
         if_flush = 1'b0;
         trap_go  = 1'b0;
         fwd_ex   = 2'b00;
         fwd_mem  = 2'b00;
         fwd_load = 2'b00;
         state_o  = 3'(HZ_RUN);
      end
   end

endmodule
